// File: rtl/mm_dump_pkg.sv
// Shared types and helpers for the mm_dump memory read-back streamer.
package mm_dump_pkg;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_FETCH,
    MD_SEND,
    MD_CSUM,
    MD_FIN
  } md_state_t;

  localparam logic [31:0] WORD_STEP = 32'd4;

  // Little-endian byte lane select: index 0 is bits [7:0].
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mm_dump.sv
// Memory dump streamer: reads WORD_CNT words from mm and emits them as a
// little-endian byte stream on a valid/ready port, followed by a mod-256 checksum.
module mm_dump
  import mm_dump_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [31:0]      BASE_ADDR,
  input  logic [CNT_W-1:0] WORD_CNT,
  output logic [31:0]      MEM_ADDR,
  input  logic [31:0]      MEM_DATA,
  output logic [7:0]       TX_DATA,
  output logic             TX_VALID,
  input  logic             TX_READY,
  output logic             BUSY,
  output logic             DONE
);

  md_state_t        state, state_nxt;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] remain_q;
  logic [31:0]      word_q;
  logic [7:0]       csum_q;
  logic [1:0]       idx_q;
  logic             lat_q;
  logic             fetch_done;
  logic             hs;
  logic             last_byte;
  logic [31:0]      base_aligned;

  assign base_aligned = {BASE_ADDR[31:2], 2'b00};
  assign fetch_done   = (MEM_RD_LAT == 0) ? 1'b1 : lat_q;
  assign hs           = TX_VALID && TX_READY;
  assign last_byte    = (idx_q == 2'd3);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= MD_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE:  if (START) state_nxt = (WORD_CNT != '0) ? MD_FETCH : MD_CSUM;
      MD_FETCH: if (fetch_done) state_nxt = MD_SEND;
      MD_SEND:  if (hs && last_byte)
                  state_nxt = (remain_q != CNT_W'(1)) ? MD_FETCH : MD_CSUM;
      MD_CSUM:  if (hs) state_nxt = MD_FIN;
      MD_FIN:   state_nxt = MD_IDLE;
      default:  state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    TX_DATA  = '0;
    TX_VALID = 1'b0;
    BUSY     = (state != MD_IDLE);
    DONE     = (state == MD_FIN);
    case (state)
      MD_SEND: begin
        TX_DATA  = word_byte(word_q, idx_q);
        TX_VALID = 1'b1;
      end
      MD_CSUM: begin
        TX_DATA  = csum_q;
        TX_VALID = 1'b1;
      end
      default: ;
    endcase
  end

  // MEM_ADDR is loaded only when a fetch is about to start, so it holds
  // through SEND, CSUM and IDLE (an empty dump never touches it).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      MEM_ADDR <= '0;
      addr_q   <= '0;
      remain_q <= '0;
      word_q   <= '0;
      csum_q   <= '0;
      idx_q    <= '0;
      lat_q    <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (START) begin
            addr_q   <= base_aligned;
            remain_q <= WORD_CNT;
            csum_q   <= '0;
            lat_q    <= 1'b0;
            if (WORD_CNT != '0) MEM_ADDR <= base_aligned;
          end
        end
        MD_FETCH: begin
          if (fetch_done) begin
            word_q <= MEM_DATA;
            idx_q  <= '0;
            lat_q  <= 1'b0;
          end else begin
            lat_q  <= 1'b1;
          end
        end
        MD_SEND: begin
          if (hs) begin
            csum_q <= csum_q + TX_DATA;
            idx_q  <= idx_q + 2'd1;
            if (last_byte) begin
              remain_q <= remain_q - CNT_W'(1);
              addr_q   <= addr_q + WORD_STEP;
              if (remain_q != CNT_W'(1)) MEM_ADDR <= addr_q + WORD_STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_dump.sv
// Directed bench for mm_dump: one registered-read instance and one
// combinational-read instance, each fed from a small fixed memory image.
module tb_mm_dump;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        start_a = 1'b0, ready_a = 1'b1;
  logic [31:0] base_a = '0;
  logic [15:0] cnt_a = '0;
  logic [31:0] mem_addr_a, mem_data_a = '0;
  logic [7:0]  tx_data_a;
  logic        tx_valid_a, busy_a, done_a;

  logic        start_b = 1'b0, ready_b = 1'b1;
  logic [31:0] base_b = '0;
  logic [15:0] cnt_b = '0;
  logic [31:0] mem_addr_b, mem_data_b;
  logic [7:0]  tx_data_b;
  logic        tx_valid_b, busy_b, done_b;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  byte_q[$];
  int          cyc_q[$];
  logic [31:0] trace_q[$];
  logic [7:0]  hold_q[$];
  int          done_cnt, done_cyc;
  bit          timed_out, busy_at_done;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h4433_2211;
      32'h0000_0014: return 32'hDDCC_BBAA;
      32'hFFFF_FFFC: return 32'h0403_0201;
      32'h0000_0000: return 32'h0807_0605;
      32'h0000_0020: return 32'h8765_4321;
      32'h0000_0024: return 32'h0FED_CBA9;
      32'h0000_0028: return 32'h5A5A_A5A5;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) mem_data_a <= mem_word(mem_addr_a);
  assign mem_data_b = mem_word(mem_addr_b);

  mm_dump #(.MEM_RD_LAT(1), .CNT_W(16)) u_dut_a (
    .CLK(clk), .RST(rst_n), .START(start_a), .BASE_ADDR(base_a), .WORD_CNT(cnt_a),
    .MEM_ADDR(mem_addr_a), .MEM_DATA(mem_data_a), .TX_DATA(tx_data_a),
    .TX_VALID(tx_valid_a), .TX_READY(ready_a), .BUSY(busy_a), .DONE(done_a)
  );

  mm_dump #(.MEM_RD_LAT(0), .CNT_W(16)) u_dut_b (
    .CLK(clk), .RST(rst_n), .START(start_b), .BASE_ADDR(base_b), .WORD_CNT(cnt_b),
    .MEM_ADDR(mem_addr_b), .MEM_DATA(mem_data_b), .TX_DATA(tx_data_b),
    .TX_VALID(tx_valid_b), .TX_READY(ready_b), .BUSY(busy_b), .DONE(done_b)
  );

  // Runs one dump (cycle 0 = cycle in which START is sampled) and records the
  // accepted bytes, their handshake cycles, MEM_ADDR changes and stall samples.
  task automatic collect(input bit sel, input logic [31:0] base, input logic [15:0] cnt,
                         input int stall_at, input int stall_len, input int restart_cyc);
    int cyc, stall_rem;
    logic [31:0] last_addr, addr;
    logic [7:0] data;
    logic vld, dn, bsy;
    bit fin;
    byte_q.delete(); cyc_q.delete(); trace_q.delete(); hold_q.delete();
    done_cnt = 0; done_cyc = -1; timed_out = 0; busy_at_done = 0;
    stall_rem = stall_len;
    @(negedge clk);
    last_addr = sel ? mem_addr_b : mem_addr_a;
    if (sel) begin start_b = 1; base_b = base; cnt_b = cnt; ready_b = 1; end
    else     begin start_a = 1; base_a = base; cnt_a = cnt; ready_a = 1; end
    cyc = 0; fin = 0;
    while (!fin) begin
      @(negedge clk); cyc++;
      // Other inputs are scrambled after START to show they are not resampled.
      if (sel) begin start_b = (cyc == restart_cyc); base_b = 32'h40; cnt_b = 16'd7; end
      else     begin start_a = (cyc == restart_cyc); base_a = 32'h40; cnt_a = 16'd7; end
      vld  = sel ? tx_valid_b : tx_valid_a;
      data = sel ? tx_data_b  : tx_data_a;
      addr = sel ? mem_addr_b : mem_addr_a;
      dn   = sel ? done_b     : done_a;
      bsy  = sel ? busy_b     : busy_a;
      if (addr != last_addr) trace_q.push_back(addr);
      last_addr = addr;
      if (dn) begin done_cnt++; done_cyc = cyc; busy_at_done = bsy; end
      if (vld && byte_q.size() == stall_at && stall_rem > 0) begin
        if (sel) ready_b = 0; else ready_a = 0;
        stall_rem--;
        hold_q.push_back(data);
      end else begin
        if (sel) ready_b = 1; else ready_a = 1;
        if (vld) begin byte_q.push_back(data); cyc_q.push_back(cyc); end
      end
      if (done_cyc >= 0 && cyc > done_cyc) fin = 1;
      if (cyc > 300) begin timed_out = 1; fin = 1; end
    end
    if (sel) begin start_b = 0; ready_b = 1; end else begin start_a = 0; ready_a = 1; end
  endtask

  task automatic test_reset();
    #3 rst_n = 0;
    #2;
    vectors++; if (tx_valid_a !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid_a); end
    vectors++; if (tx_data_a !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h expected 00", tx_data_a); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done_a); end
    vectors++; if (mem_addr_a !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr_a); end
    vectors++; if (busy_b !== 1'b0 || tx_valid_b !== 1'b0) begin miscompares++; $display("FAIL reset_b: got busy=%b valid=%b expected 0/0", busy_b, tx_valid_b); end
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic check_stream(input string nm, input logic [7:0] exp_bytes[$], input int exp_cyc[$]);
    // Byte/cycle comparison of the last collected dump against expected tables.
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL %s_timeout: got timeout expected done", nm); end
    vectors++; if (byte_q.size() != exp_bytes.size()) begin miscompares++; $display("FAIL %s_count: got %0d expected %0d", nm, byte_q.size(), exp_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < byte_q.size(); i++) begin
      vectors++; if (byte_q[i] !== exp_bytes[i]) begin miscompares++; $display("FAIL %s_byte%0d: got %h expected %h", nm, i, byte_q[i], exp_bytes[i]); end
    end
    for (int i = 0; i < exp_cyc.size() && i < cyc_q.size(); i++) begin
      vectors++; if (cyc_q[i] != exp_cyc[i]) begin miscompares++; $display("FAIL %s_cycle%0d: got %0d expected %0d", nm, i, cyc_q[i], exp_cyc[i]); end
    end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL %s_done_pulses: got %0d expected 1", nm, done_cnt); end
    vectors++; if (busy_at_done !== 1'b1) begin miscompares++; $display("FAIL %s_busy_at_done: got %b expected 1", nm, busy_at_done); end
  endtask

  task automatic test_readback();
    collect(0, 32'h10, 16'd2, -1, 0, -1);
    check_stream("readback", '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB8},
                 '{3, 4, 5, 6, 9, 10, 11, 12, 13});
    vectors++; if (done_cyc != 14) begin miscompares++; $display("FAIL readback_done_cycle: got %0d expected 14", done_cyc); end
    vectors++; if (trace_q.size() != 2) begin miscompares++; $display("FAIL readback_addr_steps: got %0d expected 2", trace_q.size()); end
    else begin
      vectors++; if (trace_q[0] !== 32'h10) begin miscompares++; $display("FAIL readback_addr0: got %h expected 00000010", trace_q[0]); end
      vectors++; if (trace_q[1] !== 32'h14) begin miscompares++; $display("FAIL readback_addr1: got %h expected 00000014", trace_q[1]); end
    end
  endtask

  task automatic test_backpressure();
    collect(0, 32'h10, 16'd2, 2, 5, -1);
    check_stream("backpressure", '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB8},
                 '{3, 4, 10, 11, 14, 15, 16, 17, 18});
    vectors++; if (hold_q.size() != 5) begin miscompares++; $display("FAIL backpressure_hold_len: got %0d expected 5", hold_q.size()); end
    for (int i = 0; i < hold_q.size(); i++) begin
      vectors++; if (hold_q[i] !== 8'h33) begin miscompares++; $display("FAIL backpressure_hold%0d: got %h expected 33", i, hold_q[i]); end
    end
    vectors++; if (done_cyc != 19) begin miscompares++; $display("FAIL backpressure_done_cycle: got %0d expected 19", done_cyc); end
  endtask

  task automatic test_ignored_start();
    collect(0, 32'h10, 16'd2, -1, 0, 4);
    check_stream("ignored_start", '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB8},
                 '{3, 4, 5, 6, 9, 10, 11, 12, 13});
    vectors++; if (done_cyc != 14) begin miscompares++; $display("FAIL ignored_start_done_cycle: got %0d expected 14", done_cyc); end
  endtask

  task automatic test_empty();
    collect(0, 32'h30, 16'd0, -1, 0, -1);
    check_stream("empty", '{8'h00}, '{1});
    vectors++; if (done_cyc != 2) begin miscompares++; $display("FAIL empty_done_cycle: got %0d expected 2", done_cyc); end
    vectors++; if (trace_q.size() != 0) begin miscompares++; $display("FAIL empty_addr_moved: got %0d changes expected 0", trace_q.size()); end
    vectors++; if (mem_addr_a !== 32'h14) begin miscompares++; $display("FAIL empty_mem_addr: got %h expected 00000014", mem_addr_a); end
  endtask

  task automatic test_wrap();
    collect(0, 32'hFFFF_FFFE, 16'd2, -1, 0, -1);
    check_stream("wrap", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24},
                 '{3, 4, 5, 6, 9, 10, 11, 12, 13});
    vectors++; if (trace_q.size() != 2) begin miscompares++; $display("FAIL wrap_addr_steps: got %0d expected 2", trace_q.size()); end
    else begin
      vectors++; if (trace_q[0] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr0: got %h expected fffffffc", trace_q[0]); end
      vectors++; if (trace_q[1] !== 32'h0) begin miscompares++; $display("FAIL wrap_addr1: got %h expected 00000000", trace_q[1]); end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    @(negedge clk); start_a = 1; base_a = 32'h10; cnt_a = 16'd2; ready_a = 1;
    @(negedge clk); start_a = 0;
    w = 0;
    while (!tx_valid_a && w < 20) begin @(negedge clk); w++; end
    vectors++; if (tx_valid_a !== 1'b1) begin miscompares++; $display("FAIL reset_mid_reach_send: got valid=%b expected 1", tx_valid_a); end
    #2 rst_n = 0;
    #1;
    vectors++; if (tx_valid_a !== 1'b0) begin miscompares++; $display("FAIL reset_mid_tx_valid: got %b expected 0", tx_valid_a); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_mid_busy: got %b expected 0", busy_a); end
    vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL reset_mid_done: got %b expected 0", done_a); end
    vectors++; if (mem_addr_a !== 32'h0) begin miscompares++; $display("FAIL reset_mid_mem_addr: got %h expected 0", mem_addr_a); end
    @(negedge clk); @(negedge clk); rst_n = 1;
    collect(0, 32'h14, 16'd1, -1, 0, -1);
    check_stream("after_reset", '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E}, '{3, 4, 5, 6, 7});
    vectors++; if (trace_q.size() != 1 || trace_q[0] !== 32'h14) begin miscompares++; $display("FAIL after_reset_addr: got %0d changes expected one to 00000014", trace_q.size()); end
  endtask

  task automatic test_latency0();
    collect(1, 32'h20, 16'd3, -1, 0, -1);
    check_stream("lat0", '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hED, 8'h0F,
                           8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'hBE},
                 '{2, 3, 4, 5, 7, 8, 9, 10, 12, 13, 14, 15, 16});
    vectors++; if (done_cyc != 17) begin miscompares++; $display("FAIL lat0_done_cycle: got %0d expected 17", done_cyc); end
    vectors++; if (trace_q.size() != 3) begin miscompares++; $display("FAIL lat0_addr_steps: got %0d expected 3", trace_q.size()); end
    else begin
      vectors++; if (trace_q[2] !== 32'h28) begin miscompares++; $display("FAIL lat0_addr2: got %h expected 00000028", trace_q[2]); end
    end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_backpressure();
    test_ignored_start();
    test_empty();
    test_wrap();
    test_reset_mid();
    test_latency0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
